// File: rtl/uart_dbg_frame_decoder.sv
// uart_dbg_frame_decoder: parses host byte frames into DMI requests and frames DMI responses back to the host
module uart_dbg_frame_decoder #(
  parameter int ABITS = 7,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  output logic             RE_O,
  input  logic [7:0]       DREC_I,
  input  logic             RX_EMPTY_I,
  output logic             WE_O,
  output logic [7:0]       DSEND_O,
  input  logic             TX_READY_I,
  output logic             DMI_REQ_VALID_O,
  input  logic             DMI_REQ_READY_I,
  output logic [ABITS-1:0] DMI_REQ_ADDR_O,
  output logic [1:0]       DMI_REQ_OP_O,
  output logic [31:0]      DMI_REQ_DATA_O,
  input  logic             DMI_RESP_VALID_I,
  output logic             DMI_RESP_READY_O,
  input  logic [31:0]      DMI_RESP_DATA_I,
  input  logic [1:0]       DMI_RESP_RESP_I,
  output logic             BUSY_O,
  output logic             ERR_O
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, REQ, WAIT_RESP, TX_STATUS, TX_DATA, TX_BAD} state_t;
  state_t state;
  logic [1:0] cmd, idx, resp;
  logic [31:0] wdata, rdata;
  logic [ABITS-1:0] addr;
  logic [CW-1:0] cnt;
  logic err, timeout;
  assign RE_O = RST_NI && (state inside {IDLE, RX_ADDR, RX_DATA}) && !RX_EMPTY_I;
  assign WE_O = (state inside {TX_STATUS, TX_DATA, TX_BAD}) && TX_READY_I;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign DMI_REQ_VALID_O = state == REQ;
  assign DMI_RESP_READY_O = state == WAIT_RESP;
  assign DMI_REQ_ADDR_O = addr;
  assign DMI_REQ_OP_O = cmd;
  assign DMI_REQ_DATA_O = wdata;
  assign BUSY_O = state != IDLE;
  assign ERR_O = err;
  always_comb begin
    DSEND_O = !WE_O ? 8'h00 :
              state == TX_STATUS ? {6'b0, resp} :
              state == TX_BAD ? 8'hEE :
              idx == 2'd0 ? rdata[7:0] :
              idx == 2'd1 ? rdata[15:8] :
              idx == 2'd2 ? rdata[23:16] : rdata[31:24];
  end
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state <= IDLE;
      cmd <= '0;
      idx <= '0;
      resp <= '0;
      wdata <= '0;
      rdata <= '0;
      addr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (RE_O) begin
          if (DREC_I == 8'h01 || DREC_I == 8'h02) begin
            cmd <= DREC_I[1:0];
            wdata <= '0;
            cnt <= '0;
            state <= RX_ADDR;
          end else begin
            err <= 1'b1;
            state <= TX_BAD;
          end
        end
        RX_ADDR: if (RE_O) begin
          addr <= ABITS'(DREC_I);
          cnt <= '0;
          idx <= '0;
          state <= cmd == 2'b10 ? RX_DATA : REQ;
        end else if (timeout) begin
          err <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        // data bytes arrive LSB first, so shifting in from the top lands byte k at [8k+7:8k]
        RX_DATA: if (RE_O) begin
          wdata <= {DREC_I, wdata[31:8]};
          idx <= idx + 1'b1;
          cnt <= '0;
          if (idx == 2'd3) state <= REQ;
        end else if (timeout) begin
          err <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        REQ: if (DMI_REQ_READY_I) state <= WAIT_RESP;
        WAIT_RESP: if (DMI_RESP_VALID_I) begin
          rdata <= DMI_RESP_DATA_I;
          resp <= DMI_RESP_RESP_I;
          state <= TX_STATUS;
        end
        TX_STATUS: if (TX_READY_I) begin
          idx <= '0;
          state <= cmd == 2'b01 ? TX_DATA : IDLE;
        end
        TX_DATA: if (TX_READY_I) begin
          idx <= idx + 1'b1;
          if (idx == 2'd3) state <= IDLE;
        end
        TX_BAD: if (TX_READY_I) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_dbg_frame_decoder.sv
// tb_uart_dbg_frame_decoder: directed and randomized frames checked against a frame-level reference model
module tb_uart_dbg_frame_decoder;
  localparam int TO = 16;
  logic CLK_I = 1'b0, RST_NI = 1'b0;
  logic RE_O, WE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O, BUSY_O, ERR_O;
  logic [7:0] DREC_I = 8'h00, DSEND_O;
  logic RX_EMPTY_I = 1'b0, TX_READY_I = 1'b1, DMI_REQ_READY_I = 1'b0, DMI_RESP_VALID_I = 1'b0;
  logic [6:0] DMI_REQ_ADDR_O;
  logic [1:0] DMI_REQ_OP_O, DMI_RESP_RESP_I = 2'b00;
  logic [31:0] DMI_REQ_DATA_O, DMI_RESP_DATA_I = 32'h0;
  uart_dbg_frame_decoder #(.ABITS(7), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .RE_O(RE_O), .DREC_I(DREC_I), .RX_EMPTY_I(RX_EMPTY_I),
    .WE_O(WE_O), .DSEND_O(DSEND_O), .TX_READY_I(TX_READY_I),
    .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
    .DMI_REQ_ADDR_O(DMI_REQ_ADDR_O), .DMI_REQ_OP_O(DMI_REQ_OP_O), .DMI_REQ_DATA_O(DMI_REQ_DATA_O),
    .DMI_RESP_VALID_I(DMI_RESP_VALID_I), .DMI_RESP_READY_O(DMI_RESP_READY_O),
    .DMI_RESP_DATA_I(DMI_RESP_DATA_I), .DMI_RESP_RESP_I(DMI_RESP_RESP_I),
    .BUSY_O(BUSY_O), .ERR_O(ERR_O)
  );
  always #5 CLK_I = ~CLK_I;
  int checks = 0, errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  logic [40:0] req_got[$];
  int err_cnt, stall_seen, tx_mode, tx_phase, req_stall, resp_delay, gap_run;
  bit resp_pending, prev_wait, rx_gap;
  logic [40:0] prev_req;
  logic [31:0] rsp_data;
  logic [1:0] rsp_code;
  logic last_busy, last_re, last_err;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [54:0] all_outs();
    return {RE_O, WE_O, DSEND_O, DMI_REQ_VALID_O, DMI_REQ_ADDR_O, DMI_REQ_OP_O, DMI_REQ_DATA_O,
            DMI_RESP_READY_O, BUSY_O, ERR_O};
  endfunction
  task automatic step();
    logic [40:0] cur;
    bit gap;
    @(negedge CLK_I);
    gap = rx_gap && gap_run < 3 && $urandom_range(0, 2) == 0;
    gap_run = gap ? gap_run + 1 : 0;
    RX_EMPTY_I = rx_q.size() == 0 || gap;
    DREC_I = RX_EMPTY_I ? 8'($urandom) : rx_q[0];
    TX_READY_I = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? (tx_phase % 3 == 0) : 1'($urandom_range(0, 1));
    tx_phase++;
    DMI_REQ_READY_I = DMI_REQ_VALID_O && req_stall == 0;
    if (DMI_REQ_VALID_O && req_stall > 0) req_stall--;
    if (resp_pending && resp_delay > 0) resp_delay--;
    DMI_RESP_VALID_I = resp_pending && resp_delay == 0;
    DMI_RESP_DATA_I = DMI_RESP_VALID_I ? rsp_data : $urandom;
    DMI_RESP_RESP_I = DMI_RESP_VALID_I ? rsp_code : 2'($urandom);
    #1;
    cur = {DMI_REQ_ADDR_O, DMI_REQ_OP_O, DMI_REQ_DATA_O};
    if (DMI_REQ_VALID_O && prev_wait) chk("req_stable", cur, prev_req);
    prev_wait = DMI_REQ_VALID_O && !DMI_REQ_READY_I;
    prev_req = cur;
    if (prev_wait) stall_seen++;
    chk("we_without_ready", WE_O && !TX_READY_I, 0);
    chk("dsend_idle", WE_O ? 8'h00 : DSEND_O, 0);
    if (RE_O) void'(rx_q.pop_front());
    if (WE_O) tx_got.push_back(DSEND_O);
    if (DMI_REQ_VALID_O && DMI_REQ_READY_I) begin
      req_got.push_back(cur);
      resp_pending = 1;
    end
    if (DMI_RESP_VALID_I && DMI_RESP_READY_O) resp_pending = 0;
    err_cnt += int'(ERR_O);
    last_busy = BUSY_O;
    last_re = RE_O;
    last_err = ERR_O;
    @(posedge CLK_I);
  endtask
  task automatic clear();
    tx_got.delete();
    req_got.delete();
    err_cnt = 0;
    stall_seen = 0;
    prev_wait = 0;
    tx_phase = 0;
  endtask
  task automatic finish(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    logic [7:0] exp_tx[$];
    logic [40:0] exp_req;
    bit has_req;
    int n;
    has_req = c == 8'h01 || c == 8'h02;
    exp_req = {7'(a % 128), c == 8'h01 ? 2'b01 : 2'b10, c == 8'h02 ? d : 32'h0};
    if (!has_req) exp_tx.push_back(8'hEE);
    else begin
      exp_tx.push_back({6'b0, rsp_code});
      if (c == 8'h01) for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rsp_data >> (8 * i)));
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!(!last_busy && !last_re && rx_q.size() == 0) && n < 400);
    chk("frame_done", n < 400, 1);
    chk("req_count", req_got.size(), has_req ? 1 : 0);
    if (has_req && req_got.size() > 0) chk("req_fields", req_got[0], exp_req);
    chk("tx_count", tx_got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) chk("tx_byte", i < tx_got.size() ? tx_got[i] : 8'hxx, exp_tx[i]);
    chk("err_pulses", err_cnt, has_req ? 0 : 1);
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    clear();
    rx_q.push_back(c);
    if (c == 8'h01 || c == 8'h02) rx_q.push_back(a);
    if (c == 8'h02) for (int i = 0; i < 4; i++) rx_q.push_back(8'(d >> (8 * i)));
    finish(c, a, d);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] c;
    tx_mode = 0; req_stall = 0; resp_delay = 0; resp_pending = 0; rx_gap = 0; gap_run = 0;
    rsp_data = 32'hDEADBEEF; rsp_code = 2'b00;
    #3;
    chk("reset_outputs", all_outs(), 0);
    RX_EMPTY_I = 1'b1;
    @(negedge CLK_I);
    RST_NI = 1'b1;
    frame(8'h01, 8'h11, 32'h0);
    rsp_code = 2'b00;
    frame(8'h02, 8'h10, 32'h12345678);
    tx_mode = 1; req_stall = 5;
    frame(8'h01, 8'h11, 32'h0);
    chk("req_stall_cycles", stall_seen, 5);
    tx_mode = 0;
    frame(8'h7F, 8'h00, 32'h0);
    frame(8'h01, 8'h11, 32'h0);
    clear();
    rx_q.push_back(8'h02);
    step();
    chk("to_capture", last_re, 1);
    repeat (16) step();
    chk("to_busy_at_limit", last_busy, 1);
    step();
    chk("to_idle", last_busy, 0);
    chk("to_err", last_err, 1);
    repeat (3) step();
    chk("to_no_tx", tx_got.size(), 0);
    chk("to_no_req", req_got.size(), 0);
    chk("to_err_count", err_cnt, 1);
    clear();
    rsp_code = 2'b10;
    rx_q.push_back(8'h02);
    step();
    repeat (15) step();
    rx_q.push_back(8'hA0);
    step();
    chk("limit_take", last_re, 1);
    step();
    chk("limit_busy", last_busy, 1);
    chk("limit_no_err", err_cnt, 0);
    for (int i = 0; i < 4; i++) rx_q.push_back(8'(32'hCAFE0042 >> (8 * i)));
    finish(8'h02, 8'hA0, 32'hCAFE0042);
    clear();
    rsp_data = 32'h89ABCDEF; rsp_code = 2'b01;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h33);
    n = 0;
    while (tx_got.size() < 2 && n < 100) begin
      step();
      n++;
    end
    chk("rst_reached_tx_data", tx_got.size(), 2);
    #2;
    RST_NI = 1'b0;
    RX_EMPTY_I = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    RX_EMPTY_I = 1'b1;
    @(negedge CLK_I);
    RST_NI = 1'b1;
    resp_pending = 0;
    clear();
    step();
    chk("rst_idle", last_busy, 0);
    chk("rst_no_tx", tx_got.size(), 0);
    rsp_data = 32'h01020304; rsp_code = 2'b11;
    frame(8'h01, 8'hF5, 32'h0);
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 4);
      c = n < 2 ? 8'h01 : n < 4 ? 8'h02 : 8'($urandom_range(3, 255));
      tx_mode = $urandom_range(0, 2);
      req_stall = $urandom_range(0, 3);
      resp_delay = $urandom_range(0, 3);
      rx_gap = 1'($urandom_range(0, 1));
      rsp_data = $urandom;
      rsp_code = 2'($urandom);
      frame(c, 8'($urandom), $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_dbg_frame_decoder.md
Name: uart_dbg_frame_decoder

Overview:
- Sits directly downstream of the UART interface. Consumes received bytes from its RX FIFO read port and produces response bytes into its TX FIFO write port.
- Parses fixed-format host command frames into single Debug Module Interface (DMI) requests. Returns the DMI response as a byte frame to the host.
- Protocol layer between the byte transport and the RISC-V debug module.

Parameters:
- ABITS, 7, DMI address width; bits [ABITS-1:0] of the address byte are used, upper bits ignored.
- TIMEOUT_CYCLES, 1000000, max CLK_I cycles between bytes inside a frame before abort; must be >= 2.

Ports:
- CLK_I  in  1  system clock.
- RST_NI  in  1  asynchronous active-low reset.
- RE_O  out  1  pop request to the UART RX FIFO.
- DREC_I  in  8  RX byte; valid in the cycle RE_O=1.
- RX_EMPTY_I  in  1  UART RX FIFO empty.
- WE_O  out  1  push strobe to the UART TX FIFO.
- DSEND_O  out  8  TX byte; valid when WE_O=1.
- TX_READY_I  in  1  UART TX FIFO not full.
- DMI_REQ_VALID_O  out  1  request valid.
- DMI_REQ_READY_I  in  1  request accepted.
- DMI_REQ_ADDR_O  out  ABITS  request address.
- DMI_REQ_OP_O  out  2  01 = read, 10 = write.
- DMI_REQ_DATA_O  out  32  write data (0 for reads).
- DMI_RESP_VALID_I  in  1  response valid.
- DMI_RESP_READY_O  out  1  response accept.
- DMI_RESP_DATA_I  in  32  response data.
- DMI_RESP_RESP_I  in  2  DMI response code.
- BUSY_O  out  1  high in every state except IDLE.
- ERR_O  out  1  one-cycle pulse on bad command or timeout.

Behaviour:
- Reset (async, RST_NI=0): state=IDLE; all outputs 0; registers (cmd, addr, data, byte counter, timeout counter) cleared. Reset mid-frame discards the partial frame; bytes already popped are lost.
- Frame format, host->block:
  - CMD byte: 0x01 = read, 0x02 = write.
  - ADDR byte.
  - Write only: 4 data bytes, LSB first.
- Frame format, block->host:
  - STATUS byte = {6'b0, resp[1:0]}.
  - Read only: 4 response data bytes, LSB first.
  - Bad command: single byte 0xEE.
- Byte intake:
  - In IDLE, RX_ADDR and RX_DATA, RE_O = !RX_EMPTY_I (combinational).
  - The byte on DREC_I is captured at the same clock edge.
  - At most one byte per cycle.
  - RE_O=0 in all other states.
- States:
  - IDLE: on byte 0x01/0x02, latch cmd -> RX_ADDR. Any other byte -> TX_BAD, ERR_O pulse.
  - RX_ADDR: on byte, latch addr. Read -> REQ; write -> RX_DATA, byte count = 0.
  - RX_DATA: on byte k (0..3), store it into data[8k+7:8k]. After k=3 -> REQ.
  - REQ: DMI_REQ_VALID_O=1 with addr/op/data held stable until DMI_REQ_READY_I=1 -> WAIT_RESP. The first REQ cycle follows the last captured byte by exactly 1 cycle.
  - WAIT_RESP: DMI_RESP_READY_O=1. On DMI_RESP_VALID_I, latch data and resp -> TX_STATUS.
  - TX_STATUS: WE_O = TX_READY_I, DSEND_O = status. On push, read -> TX_DATA (index 0); write -> IDLE.
  - TX_DATA: WE_O = TX_READY_I, DSEND_O = rdata byte[index]. Index increments per push; after index 3 -> IDLE.
  - TX_BAD: WE_O = TX_READY_I, DSEND_O = 0xEE; on push -> IDLE.
- TX pushes:
  - WE_O is high only in cycles where TX_READY_I=1. Back-to-back pushes are allowed.
  - When TX_READY_I is low, the state and DSEND_O hold.
  - DSEND_O = 0 when WE_O=0.
- Timeout:
  - The counter runs only in RX_ADDR and RX_DATA. It clears on every captured byte and on entry to those states.
  - At the cycle the counter reaches TIMEOUT_CYCLES-1 with no byte captured: -> IDLE, ERR_O pulse, no response sent.
  - If a byte arrives in the same cycle as the limit, the byte wins and no timeout occurs.
- No timeout in REQ or WAIT_RESP; a hung DMI side is recovered by reset only.
- RX bytes arriving during REQ, WAIT_RESP and TX states remain in the UART FIFO and are parsed after return to IDLE.
- BUSY_O is registered state decode (state != IDLE).

Test Plan:
- Read:
  - Stimulus: bytes 0x01, 0x11; DMI accepts immediately; responds data 0xDEADBEEF, resp 00.
  - Required: DMI_REQ_ADDR_O=0x11, OP=01, DATA=0. TX bytes 0x00, 0xEF, 0xBE, 0xAD, 0xDE. BUSY_O returns to 0.
- Write:
  - Stimulus: bytes 0x02, 0x10, 0x78, 0x56, 0x34, 0x12; response resp 00.
  - Required: ADDR=0x10, OP=10, DATA=0x12345678. Exactly one TX byte, 0x00.
- Backpressure:
  - Stimulus: read; DMI_REQ_READY_I held low 5 cycles; TX_READY_I toggles 1,0,0,1...
  - Required: REQ outputs stable for all 5 cycles. No WE_O while TX_READY_I=0. Same 5-byte sequence as the read case, with no duplicates.
- Bad command:
  - Stimulus: byte 0x7F.
  - Required: ERR_O 1-cycle pulse; TX byte 0xEE; no DMI request. A following valid read frame is processed normally.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: byte 0x02, then RX idle 20 cycles.
  - Required: return to IDLE 16 cycles after the capture of 0x02 (counter cleared on capture, limit reached at 15); ERR_O pulse; no TX bytes. A byte arriving exactly at count 15 is accepted and no timeout occurs.
- Reset mid-op:
  - Stimulus: assert RST_NI asynchronously during TX_DATA.
  - Required: all outputs 0 immediately (before the next edge); state IDLE after release.
